// File: rtl/serial_alu_pkg.sv
// Shared definitions for the bit-serial ALU: command codes, FSM encoding,
// response record and the subtract-style command helper.
package alu_defs;

    localparam int ALU_WIDTH = 32;

    typedef logic [2:0] cmd_t;

    localparam cmd_t CMD_ADD  = 3'd0;
    localparam cmd_t CMD_SUB  = 3'd1;
    localparam cmd_t CMD_XOR  = 3'd2;
    localparam cmd_t CMD_SLT  = 3'd3;
    localparam cmd_t CMD_AND  = 3'd4;
    localparam cmd_t CMD_NAND = 3'd5;
    localparam cmd_t CMD_NOR  = 3'd6;
    localparam cmd_t CMD_OR   = 3'd7;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef struct packed {
        logic [ALU_WIDTH-1:0] result;
        logic                 carryout;
        logic                 overflow;
        logic                 zero;
    } alu_rsp_t;

    // SUB and SLT both run A + ~B + 1 through the adder.
    function automatic logic is_sub(input cmd_t cmd);
        return (cmd == CMD_SUB) || (cmd == CMD_SLT);
    endfunction

endpackage

// File: rtl/serial_alu_if.sv
// Request/response bundle of the serial ALU; master issues requests and
// consumes responses, slave is the ALU.
interface serial_alu_if
    import alu_defs::*;
#(
    parameter int WIDTH = 32
);
    logic             req_valid;
    logic             req_ready;
    logic [WIDTH-1:0] operandA;
    logic [WIDTH-1:0] operandB;
    cmd_t             command;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] result;
    logic             carryout;
    logic             overflow;
    logic             zero;

    modport master (
        output req_valid, operandA, operandB, command, rsp_ready,
        input  req_ready, rsp_valid, result, carryout, overflow, zero
    );

    modport slave (
        input  req_valid, operandA, operandB, command, rsp_ready,
        output req_ready, rsp_valid, result, carryout, overflow, zero
    );
endinterface

// File: rtl/alu_bit_slice.sv
// One-bit ALU slice: full adder for ADD/SUB/SLT (B inverted for the latter
// two) and plain bitwise logic for the remaining commands.
module alu_bit_slice
    import alu_defs::*;
(
    input  logic a,
    input  logic b,
    input  logic cin,
    input  cmd_t command,
    output logic res_bit,
    output logic cout
);

    logic b_s;

    // Per-bit result and carry for the selected command
    always_comb begin
        b_s     = is_sub(command) ? ~b : b;
        res_bit = 1'b0;
        cout    = 1'b0;
        case (command)
            CMD_ADD, CMD_SUB, CMD_SLT: begin
                res_bit = a ^ b_s ^ cin;
                cout    = (a & b_s) | (a & cin) | (b_s & cin);
            end
            CMD_XOR:  res_bit = a ^ b;
            CMD_AND:  res_bit = a & b;
            CMD_NAND: res_bit = ~(a & b);
            CMD_NOR:  res_bit = ~(a | b);
            CMD_OR:   res_bit = a | b;
            default: begin
                res_bit = 1'b0;
                cout    = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/serial_alu.sv
// Bit-serial ALU: operands are shifted LSB first through a single bit slice,
// one bit per clock, and the result is assembled in a shift register.
module serial_alu
    import alu_defs::*;
#(
    parameter int WIDTH = 32
)(
    input  logic        clk,
    input  logic        rst_n,
    serial_alu_if.slave bus
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    cmd_t             cmd_q, cmd_d;
    logic             carry_q, carry_d;
    logic             nz_q, nz_d;
    logic             carryout_q, carryout_d;
    logic             overflow_q, overflow_d;
    logic             zero_q, zero_d;
    logic             req_ready_q, req_ready_d;
    logic             rsp_valid_q, rsp_valid_d;

    logic             bit_s;
    logic             cout_s;
    logic             last_s;
    logic             arith_s;
    logic             ovf_s;
    logic             slt_s;

    alu_bit_slice u_slice (
        .a       (a_q[0]),
        .b       (b_q[0]),
        .cin     (carry_q),
        .command (cmd_q),
        .res_bit (bit_s),
        .cout    (cout_s)
    );

    assign last_s  = (cnt_q == CW'(WIDTH - 1));
    assign arith_s = (cmd_q == CMD_ADD) || (cmd_q == CMD_SUB);
    // carry_q is the carry into the bit being processed, so on the MSB it is
    // the carry-in used for signed overflow.
    assign ovf_s   = carry_q ^ cout_s;
    assign slt_s   = bit_s ^ ovf_s;

    // Next-state and datapath update
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        a_d        = a_q;
        b_d        = b_q;
        res_d      = res_q;
        cmd_d      = cmd_q;
        carry_d    = carry_q;
        nz_d       = nz_q;
        carryout_d = carryout_q;
        overflow_d = overflow_q;
        zero_d     = zero_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid && req_ready_q) begin
                    state_d = ST_RUN;
                    a_d     = bus.operandA;
                    b_d     = bus.operandB;
                    cmd_d   = bus.command;
                    cnt_d   = '0;
                    carry_d = is_sub(bus.command);
                    nz_d    = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                res_d   = {bit_s, res_q[WIDTH-1:1]};
                carry_d = cout_s;
                nz_d    = nz_q | bit_s;
                cnt_d   = cnt_q + CW'(1);
                if (last_s) begin
                    state_d = ST_DONE;
                    if (cmd_q == CMD_SLT) begin
                        res_d      = {{(WIDTH-1){1'b0}}, slt_s};
                        carryout_d = 1'b0;
                        overflow_d = 1'b0;
                        zero_d     = ~slt_s;
                    end else begin
                        carryout_d = arith_s & cout_s;
                        overflow_d = arith_s & ovf_s;
                        zero_d     = ~(nz_q | bit_s);
                    end
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DONE: begin
                if (rsp_valid_q && bus.rsp_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        req_ready_d = (state_d == ST_IDLE);
        rsp_valid_d = (state_d == ST_DONE);
    end

    // State and datapath registers; reset aborts any operation in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            res_q       <= '0;
            cmd_q       <= CMD_ADD;
            carry_q     <= 1'b0;
            nz_q        <= 1'b0;
            carryout_q  <= 1'b0;
            overflow_q  <= 1'b0;
            zero_q      <= 1'b0;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            a_q         <= a_d;
            b_q         <= b_d;
            res_q       <= res_d;
            cmd_q       <= cmd_d;
            carry_q     <= carry_d;
            nz_q        <= nz_d;
            carryout_q  <= carryout_d;
            overflow_q  <= overflow_d;
            zero_q      <= zero_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.result    = res_q;
    assign bus.carryout  = carryout_q;
    assign bus.overflow  = overflow_q;
    assign bus.zero      = zero_q;

endmodule
